// File: rtl/pwm_fader.sv
// Slew-rate limiter feeding the pwm duty_cycle input: ramps toward a handshaked target
// in clamped steps every (prescale+1) clocks. Define PWM_FADER_RETARGET_EN to accept targets mid-ramp.
module pwm_fader #(
   parameter int BITS          = 16,
   parameter int PRESCALE_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [BITS-1:0]          target,
   input  logic                     target_valid,
   output logic                     target_ready,
   input  logic [BITS-1:0]          step,
   input  logic [PRESCALE_BITS-1:0] prescale,
   output logic [BITS-1:0]          duty_cycle,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic {S_IDLE, S_RAMP} state_t;

   state_t                   r_state, w_state_next;
   logic [BITS-1:0]          r_duty, w_duty_next;
   logic [BITS-1:0]          r_tgt, w_tgt_next;
   logic [PRESCALE_BITS-1:0] r_cnt, w_cnt_next;
   logic                     r_busy, r_done, w_done_next;

   logic                     w_ready, w_accept, w_tick;
   logic [BITS-1:0]          w_goal, w_step_eff, w_stepped;
   logic [BITS:0]            w_gap, w_step_ext, w_sum, w_diff;

`ifdef PWM_FADER_RETARGET_EN
   assign w_ready = reset_n;
`else
   assign w_ready = reset_n && (r_state == S_IDLE);
`endif

   assign w_accept = target_valid && w_ready;
   assign w_tick   = (r_state == S_RAMP) && (r_cnt == prescale);

   // A target accepted on a tick edge is stepped toward immediately.
   assign w_goal     = w_accept ? target : r_tgt;
   assign w_step_eff = (step == '0) ? BITS'(1) : step;
   assign w_step_ext = {1'b0, w_step_eff};

   // Distance and candidate moves at BITS+1 so clamping never wraps.
   assign w_gap  = (w_goal >= r_duty) ? ({1'b0, w_goal} - {1'b0, r_duty})
                                      : ({1'b0, r_duty} - {1'b0, w_goal});
   assign w_sum  = {1'b0, r_duty} + w_step_ext;
   assign w_diff = {1'b0, r_duty} - w_step_ext;

   always_comb begin
      w_stepped = w_goal;
      if (w_gap > w_step_ext) begin
         w_stepped = (w_goal > r_duty) ? w_sum[BITS-1:0] : w_diff[BITS-1:0];
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_duty_next  = r_duty;
      w_tgt_next   = r_tgt;
      w_cnt_next   = r_cnt;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_tgt_next = target;
               w_cnt_next = '0;
               if (target == r_duty) begin
                  w_done_next = 1'b1;
               end else begin
                  w_state_next = S_RAMP;
               end
            end
         end
         S_RAMP: begin
            w_cnt_next = w_tick ? '0 : r_cnt + PRESCALE_BITS'(1);
            if (w_accept) begin
               w_tgt_next = target;
            end
            if (w_accept && (target == r_duty)) begin
               w_state_next = S_IDLE;
               w_done_next  = 1'b1;
            end else if (w_tick) begin
               w_duty_next = w_stepped;
               if (w_stepped == w_goal) begin
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_duty  <= '0;
         r_tgt   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_duty  <= w_duty_next;
         r_tgt   <= w_tgt_next;
         r_cnt   <= w_cnt_next;
         r_busy  <= (w_state_next == S_RAMP);
         r_done  <= w_done_next;
      end
   end

   assign target_ready = w_ready;
   assign duty_cycle   = r_duty;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader: directed scenarios then random targets,
// every cycle compared against an integer-arithmetic reference model.
module tb_pwm_fader;

`ifdef PWM_FADER_RETARGET_EN
   localparam bit RET = 1'b1;
`else
   localparam bit RET = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] target = '0;
   logic        target_valid = 1'b0;
   logic        target_ready;
   logic [15:0] step = '0;
   logic [7:0]  prescale = '0;
   logic [15:0] duty_cycle;
   logic        busy;
   logic        done;

   int n_total = 0;
   int n_bad   = 0;

   pwm_fader #(.BITS(16), .PRESCALE_BITS(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .target(target), .target_valid(target_valid), .target_ready(target_ready),
      .step(step), .prescale(prescale),
      .duty_cycle(duty_cycle), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: integer duty/target, clocks elapsed since last tick.
   int m_duty = 0, m_tgt = 0, m_elapsed = 0, m_acc = 0;
   bit m_ramp = 0, m_done = 0;
   bit mo_acc;
   int mo_goal, mo_s;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_duty = 0; m_tgt = 0; m_elapsed = 0; m_ramp = 0; m_done = 0;
      end else begin
         mo_acc  = target_valid && (!m_ramp || RET);
         mo_s    = (step == 16'd0) ? 1 : int'(step);
         mo_goal = mo_acc ? int'(target) : m_tgt;
         m_done  = 0;
         if (mo_acc) m_acc++;
         if (!m_ramp) begin
            if (mo_acc) begin
               m_tgt = mo_goal;
               m_elapsed = 0;
               if (mo_goal == m_duty) m_done = 1;
               else m_ramp = 1;
            end
         end else begin
            m_tgt = mo_goal;
            m_elapsed++;
            if (mo_acc && mo_goal == m_duty) begin
               m_ramp = 0; m_done = 1;
            end else if (m_elapsed == int'(prescale) + 1) begin
               m_elapsed = 0;
               if (m_tgt > m_duty) m_duty = (m_tgt - m_duty <= mo_s) ? m_tgt : m_duty + mo_s;
               else                m_duty = (m_duty - m_tgt <= mo_s) ? m_tgt : m_duty - mo_s;
               if (m_duty == m_tgt) begin
                  m_ramp = 0; m_done = 1;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick_cycle();
      @(negedge clk);
      check("duty",  {16'd0, duty_cycle}, m_duty);
      check("busy",  {31'd0, busy}, {31'd0, m_ramp});
      check("done",  {31'd0, done}, {31'd0, m_done});
      check("ready", {31'd0, target_ready}, {31'd0, reset_n && (!m_ramp || RET)});
   endtask

   task automatic present(input logic [15:0] t, input logic [15:0] s, input logic [7:0] p,
                          input int maxc, output bit acc);
      int n0;
      target = t; step = s; prescale = p; target_valid = 1'b1;
      n0 = m_acc;
      acc = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         tick_cycle();
         if (m_acc != n0) begin
            acc = 1'b1;
            break;
         end
      end
      target_valid = 1'b0;
      $display("txn target=%h step=%h prescale=%0d accepted=%0b", t, s, p, acc);
   endtask

   task automatic wait_idle(input int maxc);
      for (int i = 0; i < maxc && m_ramp; i++) tick_cycle();
      if (m_ramp) check("idle_timeout", 32'd1, 32'd0);
      tick_cycle();
   endtask

   bit   acc;
   logic [7:0] cur_p;

   initial begin
      // Reset
      repeat (3) tick_cycle();
      check("rst_duty", {16'd0, duty_cycle}, 32'd0);
      check("rst_ready", {31'd0, target_ready}, 32'd0);
      #2 reset_n = 1'b1;
      tick_cycle();

      // 1: up ramp, one step per clock
      present(16'h0100, 16'h0040, 8'd0, 10, acc);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_duty0", {16'd0, duty_cycle}, 32'd0);
      wait_idle(20);
      check("t1_final", {16'd0, duty_cycle}, 32'h0100);
      check("t1_ready", {31'd0, target_ready}, 32'd1);

      // 2: down ramp with prescale 3, no underflow
      present(16'h0000, 16'h0070, 8'd3, 10, acc);
      wait_idle(40);
      check("t2_final", {16'd0, duty_cycle}, 32'h0000);

      // 3: clamp at the top, then equal target
      present(16'hFFF0, 16'hFFFF, 8'd0, 10, acc);
      wait_idle(10);
      present(16'hFFFF, 16'h0100, 8'd0, 10, acc);
      wait_idle(10);
      check("t3_top", {16'd0, duty_cycle}, 32'h0000FFFF);
      present(16'hFFFF, 16'h0100, 8'd0, 10, acc);
      check("t3_eq_done", {31'd0, done}, 32'd1);
      check("t3_eq_busy", {31'd0, busy}, 32'd0);
      tick_cycle();

      // 4: step 0 behaves as 1
      present(16'h0000, 16'hFFFF, 8'd0, 10, acc);
      wait_idle(10);
      present(16'h0003, 16'h0000, 8'd0, 10, acc);
      tick_cycle();
      check("t4_first", {16'd0, duty_cycle}, 32'd1);
      wait_idle(10);
      check("t4_final", {16'd0, duty_cycle}, 32'd3);

      // 5: new target presented mid-ramp
      present(16'h0000, 16'h0040, 8'd0, 10, acc);
      wait_idle(10);
      present(16'h0200, 16'h0040, 8'd0, 10, acc);
      for (int i = 0; i < 20 && m_duty != 32'h80; i++) tick_cycle();
      check("t5_at80", {16'd0, duty_cycle}, 32'h0080);
      present(16'h0000, 16'h0040, 8'd0, 3, acc);
      check("t5_acc", {31'd0, acc}, {31'd0, RET});
      wait_idle(40);
      check("t5_final", {16'd0, duty_cycle}, RET ? 32'h0000 : 32'h0200);

      // 6: asynchronous reset mid-ramp
      present(16'h1000, 16'h0010, 8'd1, 10, acc);
      repeat (10) tick_cycle();
      #2 reset_n = 1'b0;
      #1;
      check("t6_duty", {16'd0, duty_cycle}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_ready", {31'd0, target_ready}, 32'd0);
      repeat (2) tick_cycle();
      #2 reset_n = 1'b1;
      tick_cycle();
      check("t6_ready_after", {31'd0, target_ready}, 32'd1);
      check("t6_no_done", {31'd0, done}, 32'd0);
      tick_cycle();

      // Random targets
      cur_p = 8'd0;
      for (int n = 0; n < 60; n++) begin
         logic [15:0] t;
         if (!m_ramp) cur_p = 8'($urandom_range(0, 3));
         t = ($urandom_range(0, 5) == 0) ? m_duty[15:0] : 16'($urandom);
         present(t, 16'($urandom_range(16'h0400, 16'h3000)), cur_p, 2000, acc);
         if (!acc) check("rnd_accept", 32'd0, 32'd1);
         repeat ($urandom_range(0, 12)) tick_cycle();
      end
      wait_idle(2000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
